// File: rtl/hazard_bubble_ctrl.sv
// ID/EX bubble and pipeline-enable controller: load-use stalls (1..15 bubbles),
// branch/jump flushes deferred across memory freezes, and saturating perf counters.
module hazard_bubble_ctrl #(
   parameter int unsigned       CTRL_W            = 10,
   parameter int unsigned       RA_W              = 5,
   parameter int unsigned       LOAD_STALL_CYCLES = 1,
   parameter logic [CTRL_W-1:0] BUBBLE_VALUE      = {CTRL_W{1'b0}},
   parameter bit                ZERO_REG_SAFE     = 1'b1,
   parameter int unsigned       CNT_W             = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [RA_W-1:0]   id_rs,
   input  logic [RA_W-1:0]   id_rt,
   input  logic              id_uses_rt,
   input  logic              ex_mem_read,
   input  logic [RA_W-1:0]   ex_rt,
   input  logic              flush_req,
   input  logic              mem_busy,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              id_ex_write,
   output logic              stall_active,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LSTALL = 1'b1;

   localparam int unsigned       REM_W       = 4;
   localparam bit                MULTI_STALL = (LOAD_STALL_CYCLES > 1);
   localparam logic [REM_W-1:0]  REMAIN_INIT =
      REM_W'(MULTI_STALL ? LOAD_STALL_CYCLES - 2 : 0);
   localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

   logic [0:0]       state, state_nxt;
   logic [REM_W-1:0] remain, remain_nxt;
   logic             pending_flush, pending_flush_nxt;
   logic             stall_inc, flush_inc;
   logic             hz;

   // Load in EX writes a register the instruction in ID is about to read.
   always_comb begin
      hz = ex_mem_read
         & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)))
         & ~(ZERO_REG_SAFE & (ex_rt == '0));
   end

   // State, pending flush and counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         remain        <= '0;
         pending_flush <= 1'b0;
         stall_cnt     <= '0;
         flush_cnt     <= '0;
      end else begin
         state         <= state_nxt;
         remain        <= remain_nxt;
         pending_flush <= pending_flush_nxt;
         if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   // Next state and enables; priority reset > freeze > flush > stall > normal.
   always_comb begin
      state_nxt         = state;
      remain_nxt        = remain;
      pending_flush_nxt = pending_flush;
      stall_inc         = 1'b0;
      flush_inc         = 1'b0;
      ctrl_out          = ctrl_in;
      pc_write          = 1'b1;
      if_id_write       = 1'b1;
      if_id_flush       = 1'b0;
      id_ex_write       = 1'b1;
      stall_active      = 1'b0;

      if (reset) begin
         ctrl_out    = BUBBLE_VALUE;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if_id_flush = 1'b1;
      end else if (mem_busy) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_write = 1'b0;
         if (flush_req) pending_flush_nxt = 1'b1;
      end else if (flush_req || pending_flush) begin
         ctrl_out          = BUBBLE_VALUE;
         if_id_flush       = 1'b1;
         pending_flush_nxt = 1'b0;
         state_nxt         = IDLE;
         remain_nxt        = '0;
         flush_inc         = 1'b1;
      end else if ((state == LSTALL) || hz) begin
         ctrl_out     = BUBBLE_VALUE;
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         stall_active = 1'b1;
         stall_inc    = 1'b1;
         if (state == IDLE) begin
            if (MULTI_STALL) begin
               state_nxt  = LSTALL;
               remain_nxt = REMAIN_INIT;
            end
         end else if (remain == '0) begin
            state_nxt = IDLE;
         end else begin
            remain_nxt = remain - REM_W'(1);
         end
      end
   end

endmodule

// File: doc/hazard_bubble_ctrl.md
Name: hazard_bubble_ctrl

Overview:
- Parametrised successor to the ID/EX bubble mux. Detects load-use hazards, inserts one or more bubbles into the ID/EX control bundle, and drives the PC and IF/ID write enables.
- Handles taken branch/jump flushes and whole-pipeline freezes for a multi-cycle data memory. A freeze arriving with a flush defers the flush.
- Sits between the control unit and the ID/EX register. Also exports saturating stall and flush performance counters.

Parameters:
- CTRL_W, 10, width of the control bundle passed to ID/EX.
- RA_W, 5, register address width.
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..15.
- BUBBLE_VALUE, {CTRL_W{1'b0}}, control value driven when a bubble is inserted.
- ZERO_REG_SAFE, 1, when 1, a hazard on register 0 is ignored.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ctrl_in  in  CTRL_W  control bundle from the control unit.
- id_rs  in  RA_W  rs field of the instruction in ID.
- id_rt  in  RA_W  rt field of the instruction in ID.
- id_uses_rt  in  1  instruction in ID reads rt.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  RA_W  destination register of the load in EX.
- flush_req  in  1  branch taken or jump resolved this cycle.
- mem_busy  in  1  data memory not ready; the whole pipeline must hold.
- ctrl_out  out  CTRL_W  control bundle into ID/EX.
- pc_write  out  1  PC write enable.
- if_id_write  out  1  IF/ID write enable.
- if_id_flush  out  1  clear IF/ID to a NOP.
- id_ex_write  out  1  ID/EX write enable.
- stall_active  out  1  high in any cycle a bubble is inserted.
- stall_cnt  out  CNT_W  count of bubble cycles, saturating.
- flush_cnt  out  CNT_W  count of applied flushes, saturating.

Behaviour:
- State: IDLE or LSTALL. Registers: 4-bit remain counter, pending_flush flag, two counters.
- Reset (sync), register values: state=IDLE, remain=0, pending_flush=0, stall_cnt=0, flush_cnt=0.
- While reset is high, outputs are forced to: ctrl_out=BUBBLE_VALUE, pc_write=0, if_id_write=0, if_id_flush=1, id_ex_write=1, stall_active=0.
- Hazard condition, combinational: hz = ex_mem_read & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)) & !(ZERO_REG_SAFE & ex_rt==0).
- Priority per cycle: reset > freeze > flush > stall > normal.
- Freeze (mem_busy=1):
  - pc_write=0, if_id_write=0, id_ex_write=0, if_id_flush=0, ctrl_out=ctrl_in, stall_active=0.
  - state, remain and counters hold.
  - If flush_req=1, pending_flush is set.
- Flush (mem_busy=0 and (flush_req | pending_flush)):
  - if_id_flush=1, ctrl_out=BUBBLE_VALUE, pc_write=1, if_id_write=1, id_ex_write=1.
  - Next state: pending_flush=0, state=IDLE, remain=0 (this aborts any LSTALL). flush_cnt increments by 1.
  - stall_active=0.
- Stall:
  - Entry: IDLE with hz=1, or LSTALL.
  - Outputs: ctrl_out=BUBBLE_VALUE, pc_write=0, if_id_write=0, id_ex_write=1, stall_active=1. stall_cnt increments by 1.
  - IDLE with hz: if LOAD_STALL_CYCLES>1, go to LSTALL with remain=LOAD_STALL_CYCLES-2; otherwise stay IDLE.
  - LSTALL: if remain==0, go to IDLE; otherwise remain decrements.
  - Exactly LOAD_STALL_CYCLES bubble cycles result, excluding freeze cycles.
- Normal: ctrl_out=ctrl_in, pc_write=1, if_id_write=1, id_ex_write=1, if_id_flush=0.
- Counters saturate at all-ones and never wrap.
- All outputs except the counters are combinational from inputs and state, so bubble latency is 0 cycles. Counters update at the clock edge.

Test Plan:
- LOAD_STALL_CYCLES=1; ex_mem_read=1, ex_rt=5, id_rs=5, ctrl_in=0x3A5 -> same cycle: ctrl_out=0x000, pc_write=0, if_id_write=0, stall_active=1. With ex_mem_read dropped next cycle -> ctrl_out=0x3A5; stall_cnt=1.
- ex_rt=0=id_rs, ex_mem_read=1, ZERO_REG_SAFE=1 -> no stall; ctrl_out=ctrl_in. Also id_rt match with id_uses_rt=0 -> no stall.
- LOAD_STALL_CYCLES=3; one hazard pulse of 1 cycle -> exactly 3 consecutive bubble cycles, then normal; stall_cnt=3.
- LOAD_STALL_CYCLES=3; mem_busy=1 during the second bubble for 2 cycles -> all write enables 0 for those 2 cycles; 3 bubble cycles total; stall_cnt=3.
- flush_req=1 while mem_busy=1 (1 cycle), mem_busy dropping 2 cycles later -> if_id_flush=1 only in the first cycle with mem_busy=0; flush_cnt=1. Also flush_req arriving during LSTALL -> stall aborted, state=IDLE.
- CNT_W=4; 20 hazard events -> stall_cnt saturates at 15. Reset asserted mid-LSTALL -> next cycle state=IDLE and both counters 0; during reset ctrl_out=BUBBLE_VALUE and if_id_flush=1.
